fifo_buffer_v3: RTL and testbench

Parametrised successor to the FIFO-tree buffer: a single-clock circular FIFO with full-depth usage, selectable output mode, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush. It is the leaf and node storage element of the clause/literal FIFO tree and drops in wherever the previous buffer was instantiated.

---
 rtl/sat_fifo_pkg.sv | 15 +
 rtl/fifo_mem_2p.sv | 26 ++
 rtl/fifo_buffer_v3.sv | 148 ++++++++++++++
 tb/tb_fifo_buffer_v3.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_fifo_pkg.sv
// Shared constants for the clause/literal FIFO tree.
// Default geometry and output-mode encodings for fifo_buffer_v3.
package sat_fifo_pkg;

    localparam int FIFO_DW_DEF = 36;
    localparam int FIFO_AW_DEF = 5;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage array for fifo_buffer_v3.
// One synchronous write port, one asynchronous read port.
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Store the incoming word; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_buffer_v3.sv
// Single-clock circular FIFO with full-depth usage, occupancy count,
// threshold flags, sticky error flags and registered or FWFT output.
module fifo_buffer_v3
    import sat_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = FIFO_DW_DEF,
    parameter int ADDR_WIDTH    = FIFO_AW_DEF,
    parameter int FWFT          = FIFO_MODE_REG,
    parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  wren_i,
    input  logic                  rden_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = ADDR_WIDTH + 1;
    localparam bit IS_FWFT = (FWFT == FIFO_MODE_FWFT);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

    if (AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("AFULL_THRESH exceeds FIFO depth");
    end
    if (AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
        $error("AEMPTY_THRESH must be below FIFO depth");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_n;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] head_d;
    logic                  valid_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  last_left;

    // Status flags come straight from the count register.
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == DEPTH_C);
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;
    assign data_o         = data_q;
    assign valid_o        = IS_FWFT ? !empty_o : valid_q;

    // Accept decisions; a read frees a slot for a same-cycle write at full.
    always_comb begin
        rd_ok     = rden_i && (IS_FWFT ? valid_o : !empty_o);
        wr_ok     = wren_i && (!full_o || rd_ok);
        rd_ptr_n  = rd_ptr_q + ADDR_WIDTH'(rd_ok);
        last_left = (count_q == CW'(rd_ok));
        mem_raddr = IS_FWFT ? rd_ptr_n : rd_ptr_q;
        head_d    = last_left ? data_i : mem_rdata;
    end

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (data_i),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Pointers and occupancy; simultaneous read+write leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q <= rd_ptr_n;
            count_q  <= count_q + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    // Sticky error flags: dropped writes and ignored reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (clear_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wren_i && !wr_ok) begin
                ovf_q <= 1'b1;
            end
            if (rden_i && !rd_ok) begin
                udf_q <= 1'b1;
            end
        end
    end

    // Output word: popped word with a valid pulse, or the registered head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (IS_FWFT) begin
            data_q  <= head_d;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_ok;
            if (rd_ok) begin
                data_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fifo_buffer_v3.sv
// Self-checking bench for fifo_buffer_v3 in both output modes.
// A queue-based reference model tracks every cycle.
module tb_fifo_buffer_v3;

    localparam int DW = 36;
    localparam int AW = 5;
    localparam int DEPTH = 32;
    localparam int AFT = DEPTH - 4;
    localparam int AET = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          wren_i = 1'b0;
    logic          rden_i = 1'b0;

    logic [DW-1:0] r_data, f_data;
    logic          r_valid, f_valid;
    logic          r_empty, f_empty;
    logic          r_full, f_full;
    logic          r_af, f_af;
    logic          r_ae, f_ae;
    logic [AW:0]   r_count, f_count;
    logic          r_ovf, f_ovf;
    logic          r_udf, f_udf;

    fifo_buffer_v3 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut_reg (
        .clk(clk), .reset(reset), .clear_i(clear_i), .data_i(data_i),
        .wren_i(wren_i), .rden_i(rden_i), .data_o(r_data),
        .valid_o(r_valid), .empty_o(r_empty), .full_o(r_full),
        .almost_full_o(r_af), .almost_empty_o(r_ae), .count_o(r_count),
        .overflow_o(r_ovf), .underflow_o(r_udf)
    );

    fifo_buffer_v3 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .clear_i(clear_i), .data_i(data_i),
        .wren_i(wren_i), .rden_i(rden_i), .data_o(f_data),
        .valid_o(f_valid), .empty_o(f_empty), .full_o(f_full),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_count),
        .overflow_o(f_ovf), .underflow_o(f_udf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_d0 = '0;
    bit            m_v0 = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    typedef struct {
        bit            wr;
        bit            rd;
        bit            clr;
        logic [DW-1:0] d;
        int            cnt;
        logic [DW-1:0] d0;
        bit            v0;
        bit            ovf;
        bit            udf;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_d0 = '0;
        m_v0 = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(input bit wr, input bit rd, input bit clr,
                              input logic [DW-1:0] d);
        bit rok, wok;
        if (clr) begin
            model_clear();
        end else begin
            rok = rd && (mq.size() > 0);
            wok = wr && ((mq.size() < DEPTH) || rok);
            if (rd && !rok) m_udf = 1'b1;
            if (wr && !wok) m_ovf = 1'b1;
            if (rok) begin
                m_d0 = mq.pop_front();
                m_v0 = 1'b1;
            end else begin
                m_v0 = 1'b0;
            end
            if (wok) mq.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("reg.count", 64'(r_count), 64'(n));
        chk("fwft.count", 64'(f_count), 64'(n));
        chk("reg.empty", 64'(r_empty), 64'(n == 0));
        chk("fwft.empty", 64'(f_empty), 64'(n == 0));
        chk("reg.full", 64'(r_full), 64'(n == DEPTH));
        chk("fwft.full", 64'(f_full), 64'(n == DEPTH));
        chk("reg.afull", 64'(r_af), 64'(n >= AFT));
        chk("fwft.afull", 64'(f_af), 64'(n >= AFT));
        chk("reg.aempty", 64'(r_ae), 64'(n <= AET));
        chk("fwft.aempty", 64'(f_ae), 64'(n <= AET));
        chk("reg.ovf", 64'(r_ovf), 64'(m_ovf));
        chk("fwft.ovf", 64'(f_ovf), 64'(m_ovf));
        chk("reg.udf", 64'(r_udf), 64'(m_udf));
        chk("fwft.udf", 64'(f_udf), 64'(m_udf));
        chk("reg.valid", 64'(r_valid), 64'(m_v0));
        chk("reg.data", 64'(r_data), 64'(m_d0));
        chk("fwft.valid", 64'(f_valid), 64'(n > 0));
        if (n > 0) chk("fwft.data", 64'(f_data), 64'(mq[0]));
    endtask

    task automatic cyc(input bit wr, input bit rd, input bit clr,
                       input logic [DW-1:0] d);
        wren_i = wr;
        rden_i = rd;
        clear_i = clr;
        data_i = d;
        @(posedge clk);
        model_step(wr, rd, clr, d);
        #1;
        wren_i = 1'b0;
        rden_i = 1'b0;
        clear_i = 1'b0;
        check_all();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".count"}, 64'(r_count), 64'd0);
        chk({tag, ".data"}, 64'(r_data), 64'd0);
        chk({tag, ".valid"}, 64'(r_valid), 64'd0);
        chk({tag, ".empty"}, 64'(r_empty), 64'd1);
        chk({tag, ".full"}, 64'(r_full), 64'd0);
        chk({tag, ".aempty"}, 64'(r_ae), 64'd1);
        chk({tag, ".afull"}, 64'(r_af), 64'd0);
        chk({tag, ".ovf"}, 64'(r_ovf), 64'd0);
        chk({tag, ".udf"}, 64'(r_udf), 64'd0);
        chk({tag, ".f_count"}, 64'(f_count), 64'd0);
        chk({tag, ".f_valid"}, 64'(f_valid), 64'd0);
        chk({tag, ".f_data"}, 64'(f_data), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1, 0, 0, 36'h0A5, 1, 36'h0,   0, 0, 0};
        vt[1] = '{1, 0, 0, 36'h05A, 2, 36'h0,   0, 0, 0};
        vt[2] = '{0, 1, 0, 36'h0,   1, 36'h0A5, 1, 0, 0};
        vt[3] = '{0, 0, 0, 36'h0,   1, 36'h0A5, 0, 0, 0};
        vt[4] = '{1, 1, 0, 36'h111, 1, 36'h05A, 1, 0, 0};
        vt[5] = '{0, 1, 0, 36'h0,   0, 36'h111, 1, 0, 0};
        vt[6] = '{0, 1, 0, 36'h0,   0, 36'h111, 0, 0, 1};
        vt[7] = '{1, 1, 0, 36'h222, 1, 36'h111, 0, 0, 1};
        vt[8] = '{1, 0, 1, 36'h333, 0, 36'h0,   0, 0, 0};

        #12;
        reset = 1'b0;
        #1;
        check_reset_vals("reset");

        for (int i = 0; i < 9; i++) begin
            cyc(vt[i].wr, vt[i].rd, vt[i].clr, vt[i].d);
            chk($sformatf("vec%0d.count", i), 64'(r_count), 64'(vt[i].cnt));
            chk($sformatf("vec%0d.data", i), 64'(r_data), 64'(vt[i].d0));
            chk($sformatf("vec%0d.valid", i), 64'(r_valid), 64'(vt[i].v0));
            chk($sformatf("vec%0d.ovf", i), 64'(r_ovf), 64'(vt[i].ovf));
            chk($sformatf("vec%0d.udf", i), 64'(r_udf), 64'(vt[i].udf));
        end

        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, DW'(i));
        chk("fill.full", 64'(r_full), 64'd1);
        chk("fill.count", 64'(r_count), 64'd32);

        cyc(1, 1, 0, 36'h100);
        chk("fullrw.count", 64'(r_count), 64'd32);
        chk("fullrw.ovf", 64'(r_ovf), 64'd0);
        chk("fullrw.data", 64'(r_data), 64'd0);

        cyc(1, 0, 0, 36'h999);
        chk("ovf.flag", 64'(r_ovf), 64'd1);
        chk("ovf.count", 64'(r_count), 64'd32);

        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, '0);
        chk("drain.empty", 64'(r_empty), 64'd1);
        chk("drain.last", 64'(r_data), 64'h100);

        cyc(0, 1, 0, '0);
        chk("rdempty.udf", 64'(r_udf), 64'd1);
        chk("rdempty.hold", 64'(r_data), 64'h100);

        cyc(0, 0, 1, '0);
        chk("clear.ovf", 64'(f_ovf), 64'd0);
        chk("clear.udf", 64'(f_udf), 64'd0);

        cyc(1, 0, 0, 36'h0A5);
        chk("fwft.lat.valid", 64'(f_valid), 64'd1);
        chk("fwft.lat.data", 64'(f_data), 64'h0A5);
        cyc(0, 1, 0, '0);
        chk("fwft.pop.valid", 64'(f_valid), 64'd0);
        chk("fwft.pop.udf", 64'(f_udf), 64'd0);

        for (int i = 0; i < 15; i++) cyc(1, 0, 0, DW'($urandom));
        for (int i = 0; i < 100; i++) begin
            bit wr, rd;
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (mq.size() <= 11) rd = 1'b0;
            if (mq.size() >= 19) wr = 1'b0;
            cyc(wr, rd, 0, {4'h0, 32'($urandom)});
        end

        for (int i = 0; i < 40 && mq.size() < 17; i++)
            cyc(1, 0, 0, DW'($urandom));
        for (int i = 0; i < 40 && mq.size() > 17; i++)
            cyc(0, 1, 0, '0);
        chk("pre_rst.count", 64'(r_count), 64'd17);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        #1;
        reset = 1'b0;
        model_clear();

        cyc(1, 0, 0, 36'h123);
        chk("post_rst.fdata", 64'(f_data), 64'h123);
        cyc(0, 1, 0, '0);
        chk("post_rst.rdata", 64'(r_data), 64'h123);
        chk("post_rst.empty", 64'(r_empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
